sm_cpu_core: RTL and testbench

Single-cycle 32-bit MIPS-subset processor core (schoolMIPS class) that executes one instruction per clock from an external combinational instruction ROM. It contains the PC, decoder, ALU, 32x32 register file and a small internal data memory. A debug port lets the testbench read the PC or any register asynchronously.

---
 rtl/sm_cpu_pkg.sv | 27 ++
 rtl/sm_register_file.sv | 29 ++
 rtl/sm_cpu_core.sv | 116 +++++++++++
 tb/tb_sm_cpu_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_cpu_pkg.sv
// Shared opcode/funct constants and small helpers for the sm_cpu core and its benches.
package sm_cpu_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] C_SPEC  = 6'b000000;
    localparam logic [5:0] C_ADDIU = 6'b001001;
    localparam logic [5:0] C_LW    = 6'b100011;
    localparam logic [5:0] C_SW    = 6'b101011;
    localparam logic [5:0] C_LUI   = 6'b001111;
    localparam logic [5:0] C_BEQ   = 6'b000100;
    localparam logic [5:0] C_BNE   = 6'b000101;

    // SPEC function codes, instr[5:0]
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    // Neutral funct value paired with non-SPEC opcodes in disassembler tables; never decoded
    localparam logic [5:0] F_ANY   = 6'b000000;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] signExt16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/sm_register_file.sv
// 32x32 register file: two operand read ports, one debug read port, one write port.
// r0 reads as zero and ignores writes. Contents are not reset.
module sm_register_file (
    input  logic        clk,
    input  logic [4:0]  readAddr1,
    input  logic [4:0]  readAddr2,
    input  logic [4:0]  readAddr3,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [31:0] readData3,
    input  logic [4:0]  writeAddr,
    input  logic [31:0] writeData,
    input  logic        writeEnable
);

    logic [31:0] rf [0:31];

    // Synchronous write; r0 is never updated
    always_ff @(posedge clk) begin
        if (writeEnable && (writeAddr != 5'd0)) begin
            rf[writeAddr] <= writeData;
        end
    end

    assign readData1 = (readAddr1 == 5'd0) ? 32'd0 : rf[readAddr1];
    assign readData2 = (readAddr2 == 5'd0) ? 32'd0 : rf[readAddr2];
    assign readData3 = (readAddr3 == 5'd0) ? 32'd0 : rf[readAddr3];

endmodule

// File: rtl/sm_cpu_core.sv
// Single-cycle MIPS-subset core: PC, decoder, ALU, register file and internal data memory.
module sm_cpu_core
    import sm_cpu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData,
    output logic [31:0] imAddr,
    input  logic [31:0] imData
);

    localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

    logic [31:0] pc;
    logic [31:0] instr;

    assign instr  = imData;
    assign imAddr = pc;

    // Instruction fields
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sa;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] immSe;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sa    = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];
    assign immSe = signExt16(imm);

    // Register file
    logic [31:0] rsData, rtData, dbgData;
    logic [31:0] wrData;
    logic [4:0]  wrAddr;
    logic        regWe;

    sm_register_file rf (
        .clk        (clk),
        .readAddr1  (rs),
        .readAddr2  (rt),
        .readAddr3  (regAddr),
        .readData1  (rsData),
        .readData2  (rtData),
        .readData3  (dbgData),
        .writeAddr  (wrAddr),
        .writeData  (wrData),
        .writeEnable(regWe && rst_n)
    );

    assign regData = (regAddr == 5'd0) ? pc : dbgData;

    // Data memory: word-indexed, byte-offset bits dropped, index wraps at DMEM_WORDS
    logic [31:0]        dmem [0:DMEM_WORDS-1];
    logic [31:0]        effAddr;
    logic [DMEM_AW-1:0] memIdx;
    logic [31:0]        dmemRd;
    logic               memWe;

    assign effAddr = rsData + immSe;
    assign memIdx  = effAddr[DMEM_AW+1:2];
    assign dmemRd  = dmem[memIdx];

    // Decode and execute: choose write-back target/value, store enable and branch outcome
    logic takeBranch;
    always_comb begin
        regWe      = 1'b0;
        wrAddr     = rt;
        wrData     = 32'd0;
        memWe      = 1'b0;
        takeBranch = 1'b0;
        case (op)
            C_SPEC: begin
                wrAddr = rd;
                case (funct)
                    F_ADDU: begin regWe = 1'b1; wrData = rsData + rtData; end
                    F_SUBU: begin regWe = 1'b1; wrData = rsData - rtData; end
                    F_OR:   begin regWe = 1'b1; wrData = rsData | rtData; end
                    F_SRL:  begin regWe = 1'b1; wrData = rtData >> sa; end
                    F_SLTU: begin regWe = 1'b1; wrData = {31'd0, (rsData < rtData)}; end
                    default: ;
                endcase
            end
            C_ADDIU: begin regWe = 1'b1; wrData = effAddr; end
            C_LUI:   begin regWe = 1'b1; wrData = {imm, 16'h0000}; end
            C_LW:    begin regWe = 1'b1; wrData = dmemRd; end
            C_SW:    memWe = 1'b1;
            C_BEQ:   takeBranch = (rsData == rtData);
            C_BNE:   takeBranch = (rsData != rtData);
            default: ;
        endcase
    end

    logic [31:0] pcPlus1, pcNext;
    assign pcPlus1 = pc + 32'd1;
    assign pcNext  = takeBranch ? (pcPlus1 + immSe) : pcPlus1;

    // Program counter, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'd0;
        else        pc <= pcNext;
    end

    // Store port; suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (memWe && rst_n) dmem[memIdx] <= rtData;
    end

endmodule

// File: tb/tb_sm_cpu_core.sv
module tb_sm_cpu_core;
  import sm_cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [31:0] imAddr;
  logic [31:0] imData;

  logic [31:0] rom [0:255];
  logic [31:0] exp_q[$];
  logic [4:0]  addr_q[$];
  int n_compared;
  int n_mismatched;

  sm_cpu_core #(.DMEM_WORDS(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .regAddr(regAddr),
    .regData(regData),
    .imAddr (imAddr),
    .imData (imData)
  );

  // combinational instruction ROM
  assign imData = (imAddr < 32'd256) ? rom[imAddr[7:0]] : 32'h0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh);
    return {C_SPEC, s, t, d, sh, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  // driver tasks
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    clear_rom();
    rom[0] = enc_i(C_ADDIU, 0, 9, 16'd1);
    dut.rf.rf[9] = 32'h55;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      regAddr = 5'd0; #1;
      n_compared++;
      if (imAddr !== 32'd0) begin n_mismatched++; $display("FAIL reset_imaddr: got %h expected %h", imAddr, 32'd0); end
      n_compared++;
      if (regData !== 32'd0) begin n_mismatched++; $display("FAIL reset_dbgpc: got %h expected %h", regData, 32'd0); end
      regAddr = 5'd9; #1;
      n_compared++;
      if (regData !== 32'h55) begin n_mismatched++; $display("FAIL reset_nowrite: got %h expected %h", regData, 32'h55); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      regAddr = 5'd0; #1;
      n_compared++;
      if (imAddr !== e || regData !== e) begin
        n_mismatched++; $display("FAIL pc_step: imAddr %h regData %h expected %h", imAddr, regData, e);
      end
      @(negedge clk);
    end
    // asynchronous reset mid-program
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if (imAddr !== 32'd0) begin n_mismatched++; $display("FAIL async_reset: got %h expected %h", imAddr, 32'd0); end
    regAddr = 5'd9; #1;
    n_compared++;
    if (regData !== 32'd1) begin n_mismatched++; $display("FAIL reset_keep_rf: got %h expected %h", regData, 32'd1); end
  endtask

  task automatic test_alu();
    logic [31:0] e;
    clear_rom();
    rom[0] = enc_i(C_ADDIU, 0, 2, 16'd5);
    rom[1] = enc_i(C_ADDIU, 0, 3, 16'd3);
    rom[2] = enc_r(F_SUBU, 2, 3, 4, 0);
    rom[3] = enc_r(F_OR,   2, 3, 5, 0);
    rom[4] = enc_r(F_SLTU, 3, 2, 6, 0);
    rom[5] = enc_r(F_SUBU, 3, 2, 7, 0);
    rom[6] = enc_r(F_ADDU, 2, 3, 8, 0);
    rom[7] = enc_r(F_SLTU, 2, 3, 10, 0);
    addr_q.push_back(5'd2); exp_q.push_back(32'd5);
    addr_q.push_back(5'd3); exp_q.push_back(32'd3);
    addr_q.push_back(5'd4); exp_q.push_back(32'd2);
    addr_q.push_back(5'd5); exp_q.push_back(32'd7);
    addr_q.push_back(5'd6); exp_q.push_back(32'd1);
    addr_q.push_back(5'd7); exp_q.push_back(32'hFFFFFFFE);
    addr_q.push_back(5'd8); exp_q.push_back(32'd8);
    addr_q.push_back(5'd10); exp_q.push_back(32'd0);
    dut.rf.rf[10] = 32'hAAAA;
    do_reset();
    step(8);
    while (exp_q.size() > 0) begin
      regAddr = addr_q.pop_front(); e = exp_q.pop_front(); #1;
      n_compared++;
      if (regData !== e) begin n_mismatched++; $display("FAIL alu r%0d: got %h expected %h", regAddr, regData, e); end
    end
  endtask

  task automatic test_lui_srl();
    logic [31:0] e;
    clear_rom();
    rom[0] = enc_i(C_LUI, 0, 2, 16'h8000);
    rom[1] = enc_r(F_SRL, 0, 2, 3, 5'd4);
    rom[2] = enc_i(C_ADDIU, 0, 0, 16'd1);
    rom[3] = enc_r(F_ADDU, 0, 0, 4, 0);
    dut.rf.rf[4] = 32'h1111;
    addr_q.push_back(5'd2); exp_q.push_back(32'h80000000);
    addr_q.push_back(5'd3); exp_q.push_back(32'h08000000);
    addr_q.push_back(5'd4); exp_q.push_back(32'h0);
    do_reset();
    step(4);
    while (exp_q.size() > 0) begin
      regAddr = addr_q.pop_front(); e = exp_q.pop_front(); #1;
      n_compared++;
      if (regData !== e) begin n_mismatched++; $display("FAIL lui_srl r%0d: got %h expected %h", regAddr, regData, e); end
    end
  endtask

  task automatic test_memory();
    logic [31:0] e;
    clear_rom();
    dut.dmem[63] = 32'hCAFEF00D;
    dut.dmem[0]  = 32'h0;
    rom[0] = enc_i(C_ADDIU, 0, 2, 16'h1234);
    rom[1] = enc_i(C_SW, 0, 2, 16'd8);
    rom[2] = enc_i(C_LW, 0, 3, 16'd8);
    rom[3] = enc_i(C_LW, 0, 4, 16'hFFFC);
    rom[4] = enc_i(C_SW, 0, 2, 16'h0103);
    rom[5] = enc_i(C_LW, 0, 5, 16'd0);
    rom[6] = enc_i(C_LW, 0, 6, 16'd258);
    addr_q.push_back(5'd3); exp_q.push_back(32'h1234);
    addr_q.push_back(5'd4); exp_q.push_back(32'hCAFEF00D);
    addr_q.push_back(5'd5); exp_q.push_back(32'h1234);
    addr_q.push_back(5'd6); exp_q.push_back(32'h1234);
    do_reset();
    step(7);
    while (exp_q.size() > 0) begin
      regAddr = addr_q.pop_front(); e = exp_q.pop_front(); #1;
      n_compared++;
      if (regData !== e) begin n_mismatched++; $display("FAIL memory r%0d: got %h expected %h", regAddr, regData, e); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] e;
    clear_rom();
    rom[0] = enc_i(C_ADDIU, 0, 2, 16'd7);
    rom[1] = enc_i(C_BNE, 0, 0, 16'd3);
    rom[2] = enc_i(C_BNE, 2, 0, 16'd2);
    rom[3] = enc_i(C_ADDIU, 0, 11, 16'd1);
    rom[4] = enc_i(C_ADDIU, 0, 11, 16'd1);
    rom[5] = enc_i(C_BEQ, 0, 0, 16'hFFFF);
    dut.rf.rf[11] = 32'h0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    exp_q.push_back(32'd5); exp_q.push_back(32'd5); exp_q.push_back(32'd5);
    do_reset();
    regAddr = 5'd0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); #1;
      n_compared++;
      if (imAddr !== e) begin n_mismatched++; $display("FAIL branch_pc: got %h expected %h", imAddr, e); end
      @(negedge clk);
    end
    regAddr = 5'd11; #1;
    n_compared++;
    if (regData !== 32'd0) begin n_mismatched++; $display("FAIL branch_skip: got %h expected %h", regData, 32'd0); end
  endtask

  task automatic test_countdown();
    logic [31:0] ep, ev;
    logic [31:0] pcs [0:10];
    logic [31:0] v0s [0:10];
    pcs = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    v0s = '{32'hDEAD, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    clear_rom();
    rom[0] = enc_i(C_ADDIU, 0, 2, 16'd3);
    rom[1] = enc_i(C_ADDIU, 2, 2, 16'hFFFF);
    rom[2] = enc_i(C_BNE, 2, 0, 16'hFFFE);
    rom[3] = 32'hFC000000;
    rom[4] = enc_r(6'h3F, 0, 9, 2, 0);
    rom[5] = 32'hFC42FFFF;
    dut.rf.rf[2] = 32'hDEAD;
    dut.rf.rf[9] = 32'd5;
    for (int i = 0; i < 11; i++) begin
      addr_q.push_back(5'd0); exp_q.push_back(pcs[i]);
      addr_q.push_back(5'd2); exp_q.push_back(v0s[i]);
    end
    do_reset();
    while (exp_q.size() > 0) begin
      regAddr = addr_q.pop_front(); ep = exp_q.pop_front(); #1;
      n_compared++;
      if (regData !== ep) begin n_mismatched++; $display("FAIL countdown_pc: got %h expected %h", regData, ep); end
      regAddr = addr_q.pop_front(); ev = exp_q.pop_front(); #1;
      n_compared++;
      if (regData !== ev) begin n_mismatched++; $display("FAIL countdown_v0 at pc %h: got %h expected %h", ep, regData, ev); end
      @(negedge clk);
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    rst_n = 1'b0;
    regAddr = 5'd0;
    clear_rom();
    for (int i = 0; i < 32; i++) dut.rf.rf[i] = 32'h0;
    for (int i = 0; i < 64; i++) dut.dmem[i] = 32'h0;
    test_reset();
    test_alu();
    test_lui_srl();
    test_memory();
    test_branch();
    test_countdown();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
